// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: default widths, per-stage control layouts and their bubble encodings.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 96;
    localparam int unsigned PIPE_CTRL_W = 16;
    localparam int unsigned PIPE_CNT_W  = 16;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    typedef struct packed {
        aluop_t     alu_ctr;
        logic       beq;
        logic       bne;
        logic       dren;
        logic       dwen;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       halt;
        logic [4:0] rsvd;
    } idex_ctrl_t;

    // A bubble in ID/EX is an ADD with every side effect disabled.
    localparam idex_ctrl_t IDEX_NOP = '{alu_ctr: ALU_ADD, default: '0};

    typedef struct packed {
        logic                   valid;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data;
    } stage_entry_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying one control field and one payload field.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned DATA_W = PIPE_DATA_W
) ();
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input  ready);
    modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stall_ctr.sv
// Saturating event counter with synchronous clear taking priority over increment.
module pipe_stall_ctr #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, flush-to-bubble and stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = PIPE_DATA_W,
    parameter int unsigned       CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit                SKID     = 1'b1,
    parameter int unsigned       CNT_W    = PIPE_CNT_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    flush,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if,
    output logic [1:0]              occupancy,
    input  logic                    perf_clr,
    output logic [CNT_W-1:0]        stall_cnt
);
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam entry_t ENTRY_NOP = '{valid: 1'b0, ctrl: CTRL_NOP, data: '0};

    entry_t     m_q, m_d;
    entry_t     s_q, s_d;
    logic [1:0] occ_q, occ_d;
    entry_t     in_beat;
    logic       in_ready_c;
    logic       accept;
    logic       drain;

    assign in_beat    = '{valid: 1'b1, ctrl: in_if.ctrl, data: in_if.data};
    assign in_ready_c = SKID ? ~s_q.valid : (~m_q.valid | out_if.ready);
    assign accept     = en & in_if.valid & in_ready_c;
    assign drain      = en & m_q.valid & out_if.ready;

    // Next-state for main/skid entries; S only ever fills behind a valid M.
    always_comb begin
        m_d = m_q;
        s_d = s_q;
        if (en) begin
            if (flush) begin
                m_d = ENTRY_NOP;
                s_d = ENTRY_NOP;
            end else if (SKID) begin
                if (!m_q.valid) begin
                    if (accept) m_d = in_beat;
                end else if (drain) begin
                    if (s_q.valid) begin
                        m_d = s_q;
                        s_d = ENTRY_NOP;
                    end else if (accept) begin
                        m_d = in_beat;
                    end else begin
                        m_d = ENTRY_NOP;
                    end
                end else if (accept) begin
                    s_d = in_beat;
                end
            end else begin
                if (accept) begin
                    m_d = in_beat;
                end else if (drain) begin
                    m_d = ENTRY_NOP;
                end
                s_d = ENTRY_NOP;
            end
        end
        occ_d = 2'(m_d.valid) + 2'(s_d.valid);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q   <= ENTRY_NOP;
            s_q   <= ENTRY_NOP;
            occ_q <= 2'd0;
        end else begin
            m_q   <= m_d;
            s_q   <= s_d;
            occ_q <= occ_d;
        end
    end

    pipe_stall_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .clr_i (perf_clr),
        .inc_i (en & m_q.valid & ~out_if.ready & ~flush),
        .cnt_o (stall_cnt)
    );

    assign in_if.ready  = in_ready_c;
    assign out_if.valid = m_q.valid;
    assign out_if.ctrl  = m_q.ctrl;
    assign out_if.data  = m_q.data;
    assign occupancy    = occ_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three stage variants (skid, no-skid, skid with 4-bit counter) against a queue-based model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] NOP = 16'(IDEX_NOP);

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          en, flush, perf_clr, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if1 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if2 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if1 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if2 ();

    assign in_if0.valid = in_valid;  assign in_if0.ctrl = in_ctrl;  assign in_if0.data = in_data;
    assign in_if1.valid = in_valid;  assign in_if1.ctrl = in_ctrl;  assign in_if1.data = in_data;
    assign in_if2.valid = in_valid;  assign in_if2.ctrl = in_ctrl;  assign in_if2.data = in_data;
    assign out_if0.ready = out_ready;
    assign out_if1.ready = out_ready;
    assign out_if2.ready = out_ready;

    logic [1:0]  occ0, occ1, occ2;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1'b1), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in_if(in_if0), .out_if(out_if0),
        .occupancy(occ0), .perf_clr(perf_clr), .stall_cnt(sc0));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1'b0), .CNT_W(16)) u_dut1 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in_if(in_if1), .out_if(out_if1),
        .occupancy(occ1), .perf_clr(perf_clr), .stall_cnt(sc1));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1'b1), .CNT_W(4)) u_dut2 (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in_if(in_if2), .out_if(out_if2),
        .occupancy(occ2), .perf_clr(perf_clr), .stall_cnt(sc2));

    logic          ir[3];
    logic          ov[3];
    logic [CW-1:0] oc[3];
    logic [DW-1:0] od[3];
    logic [1:0]    oo[3];
    logic [15:0]   os[3];
    assign ir[0] = in_if0.ready;  assign ov[0] = out_if0.valid;  assign oc[0] = out_if0.ctrl;
    assign ir[1] = in_if1.ready;  assign ov[1] = out_if1.valid;  assign oc[1] = out_if1.ctrl;
    assign ir[2] = in_if2.ready;  assign ov[2] = out_if2.valid;  assign oc[2] = out_if2.ctrl;
    assign od[0] = out_if0.data;  assign od[1] = out_if1.data;   assign od[2] = out_if2.data;
    assign oo[0] = occ0;          assign oo[1] = occ1;           assign oo[2] = occ2;
    assign os[0] = sc0;           assign os[1] = sc1;            assign os[2] = 16'(sc2);

    // Reference: each stage is an ordered FIFO of capacity 2 (skid) or 1, plus a saturating stall count.
    beat_t       q[3][$];
    int unsigned cnt[3];

    function automatic bit skid_of(int i);
        return i != 1;
    endfunction

    function automatic int unsigned cmax(int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic model_ready(int i);
        if (skid_of(i)) return q[i].size() < 2;
        return (q[i].size() == 0) || out_ready;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 3; i++) begin
            logic          e_v;
            logic [CW-1:0] e_c;
            logic [DW-1:0] e_d;
            e_v = q[i].size() > 0;
            e_c = e_v ? q[i][0].c : NOP;
            e_d = e_v ? q[i][0].d : '0;
            check($sformatf("dut%0d.in_ready", i),  128'(ir[i]), 128'(model_ready(i)));
            check($sformatf("dut%0d.out_valid", i), 128'(ov[i]), 128'(e_v));
            check($sformatf("dut%0d.out_ctrl", i),  128'(oc[i]), 128'(e_c));
            check($sformatf("dut%0d.out_data", i),  128'(od[i]), 128'(e_d));
            check($sformatf("dut%0d.occupancy", i), 128'(oo[i]), 128'(q[i].size()));
            check($sformatf("dut%0d.stall_cnt", i), 128'(os[i]), 128'(cnt[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            cnt[i] = 0;
        end
    endtask

    // Check current outputs, advance the model by one clock with the present inputs, then clock.
    task automatic step();
        #1;
        chk_all();
        for (int i = 0; i < 3; i++) begin
            logic rdy;
            rdy = model_ready(i);
            if (perf_clr) cnt[i] = 0;
            else if (en && q[i].size() > 0 && !out_ready && !flush)
                cnt[i] = (cnt[i] == cmax(i)) ? cnt[i] : cnt[i] + 1;
            if (en) begin
                if (flush) begin
                    q[i].delete();
                end else begin
                    logic dr;
                    dr = (q[i].size() > 0) && out_ready;
                    if (dr) void'(q[i].pop_front());
                    if (in_valid && rdy) q[i].push_back('{c: in_ctrl, d: in_data});
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic e, input logic f, input logic pc);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = CW'(d) ^ 16'hC3A5;
        out_ready = r;
        en        = e;
        flush     = f;
        perf_clr  = pc;
        step();
    endtask

    initial begin
        logic [DW-1:0] k;
        RST = 1'b1;
        en = 1'b0; flush = 1'b0; perf_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        model_reset();
        @(negedge CLK);
        #1 chk_all();
        RST = 1'b0;

        // Back-pressure on the skid variant: A and B pile up, then drain in order.
        cyc(1, DW'(32'h11), 0, 1, 0, 0);
        cyc(1, DW'(32'h22), 0, 1, 0, 0);
        check("bp.occ2", 128'(occ0), 128'd2);
        check("bp.in_ready_low", 128'(ir[0]), 128'd0);
        cyc(0, '0, 1, 1, 0, 0);
        check("bp.first_0x22", 128'(od[0]), 128'h22);
        cyc(0, '0, 1, 1, 0, 0);
        check("bp.stall_cnt", 128'(sc0), 128'd1);
        check("bp.drained", 128'(ov[0]), 128'd0);

        // Reset landing between edges with M and S both full.
        cyc(1, DW'(32'h55), 0, 1, 0, 0);
        cyc(1, DW'(32'h66), 0, 1, 0, 0);
        #2 RST = 1'b1;
        #1;
        check("rst.out_valid", 128'(ov[0]), 128'd0);
        check("rst.out_ctrl", 128'(oc[0]), 128'(NOP));
        check("rst.occupancy", 128'(occ0), 128'd0);
        check("rst.in_ready", 128'(ir[0]), 128'd1);
        model_reset();
        chk_all();
        @(negedge CLK);
        RST = 1'b0;

        // Flush is ignored while en is low, then squashes everything including the offered beat.
        cyc(1, DW'(32'h44), 0, 1, 0, 0);
        cyc(0, '0, 0, 0, 1, 0);
        check("flush.held", 128'(od[0]), 128'h44);
        cyc(1, DW'(32'h33), 0, 1, 1, 0);
        check("flush.cleared", 128'(ov[0]), 128'd0);
        cyc(0, '0, 1, 1, 0, 0);
        check("flush.dropped", 128'(ov[0]), 128'd0);

        // Streaming 1..8 through the no-skid variant.
        cyc(0, '0, 1, 1, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, DW'(i), 1, 1, 0, 0);
            check($sformatf("stream.data%0d", i), 128'(od[1]), 128'(i));
            check($sformatf("stream.occ%0d", i), 128'(occ1), 128'd1);
        end
        check("stream.stall_cnt", 128'(sc1), 128'd0);

        // en toggling; the upstream beat is only advanced once it was really taken.
        k = DW'(9);
        for (int i = 0; i < 16; i++) begin
            logic e;
            e = (i % 2) == 0;
            cyc(1, k, 1, e, 0, 0);
            if (e) k = k + DW'(1);
        end
        cyc(0, '0, 1, 1, 0, 0);

        // Saturation of the 4-bit counter, then clear concurrent with a stall.
        cyc(0, '0, 1, 1, 0, 1);
        cyc(1, DW'(32'h77), 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, '0, 0, 1, 0, 0);
        check("sat.cnt15", 128'(sc2), 128'd15);
        cyc(0, '0, 0, 1, 0, 1);
        check("sat.cleared", 128'(sc2), 128'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            cyc(logic'($urandom_range(0, 99) < 60),
                {$urandom, $urandom, $urandom},
                logic'($urandom_range(0, 99) < 55),
                logic'($urandom_range(0, 99) < 80),
                logic'($urandom_range(0, 99) < 5),
                logic'($urandom_range(0, 99) < 3));
        end
        cyc(0, '0, 1, 1, 0, 0);
        cyc(0, '0, 1, 1, 0, 0);
        #1 chk_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
